// File: rtl/clock_enable_multi.sv
// ---------------------------------------------------------------------------
// clock_enable_multi
//
// Bank of independent, programmable clock-enable generators. Each channel
// runs a free counter over a period of P clock cycles, drives a level output
// that is high for the first W cycles of every period, and emits a one-cycle
// tick at the start of every period. New period/width values are captured
// into a per-channel shadow and only become active on a period boundary
// (or while the channel is idle, or on a global sync), so a running output
// never sees a truncated or stretched pulse.
//
// Ports
//   clk      : single clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   en       : [CHANNELS] per-channel run enable
//   period   : [CHANNELS*CNT_WIDTH] period per channel, slice i at i*CNT_WIDTH
//   width    : [CHANNELS*CNT_WIDTH] high-time per channel, same packing
//   load     : [CHANNELS] strobe capturing period/width slice i into shadow
//   sync     : strobe restarting all enabled channels in phase
//   out      : [CHANNELS] registered level output, high W of every P cycles
//   tick     : [CHANNELS] registered one-cycle pulse at each period start
//   pending  : [CHANNELS] high while a captured shadow is not yet active
// ---------------------------------------------------------------------------
module clock_enable_multi #(
    parameter int          CHANNELS       = 4,
    parameter int          CNT_WIDTH      = 32,
    parameter int unsigned DEFAULT_PERIOD = 25000000,
    parameter int unsigned DEFAULT_WIDTH  = 12500000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS-1:0]           en,
    input  logic [CHANNELS*CNT_WIDTH-1:0] period,
    input  logic [CHANNELS*CNT_WIDTH-1:0] width,
    input  logic [CHANNELS-1:0]           load,
    input  logic                          sync,
    output logic [CHANNELS-1:0]           out,
    output logic [CHANNELS-1:0]           tick,
    output logic [CHANNELS-1:0]           pending
);

    localparam logic [CNT_WIDTH-1:0] DEF_P = CNT_WIDTH'(DEFAULT_PERIOD);
    localparam logic [CNT_WIDTH-1:0] DEF_W = CNT_WIDTH'(DEFAULT_WIDTH);
    localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] p_act;
        logic [CNT_WIDTH-1:0] w_act;
        logic [CNT_WIDTH-1:0] p_sh;
        logic [CNT_WIDTH-1:0] w_sh;
        logic                 pend;
        logic                 out_r;
        logic                 tick_r;

        logic [CNT_WIDTH-1:0] p_in;
        logic [CNT_WIDTH-1:0] w_in;
        logic [CNT_WIDTH-1:0] p_eff;
        logic                 at_end;
        logic                 restart;
        logic                 apply;

        assign p_in = period[i*CNT_WIDTH +: CNT_WIDTH];
        assign w_in = width[i*CNT_WIDTH +: CNT_WIDTH];

        // Period values 0 and 1 both mean "tick every enabled cycle".
        assign p_eff = (p_act == '0) ? ONE : p_act;

        // ">=" rather than "==" so a counter that is somehow beyond the
        // last count still wraps instead of running through 2^CNT_WIDTH.
        assign at_end = (cnt >= (p_eff - ONE));

        // sync takes priority over the natural wrap; both restart at 0.
        assign restart = sync | at_end;

        // Config may switch only where a new period starts at the next edge:
        // on a wrap, on sync, or at any time while the channel is idle.
        assign apply = ~en[i] | restart;

        // Counter and registered outputs. out/tick are computed from the
        // counter value before this edge's update, so sync never clips them.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                out_r  <= 1'b0;
                tick_r <= 1'b0;
            end else if (en[i]) begin
                tick_r <= (cnt == '0);
                out_r  <= (cnt < w_act);
                cnt    <= restart ? '0 : (cnt + ONE);
            end else begin
                cnt    <= '0;
                out_r  <= 1'b0;
                tick_r <= 1'b0;
            end
        end

        // Active/shadow configuration. A load that coincides with an
        // applying edge bypasses the shadow so it never shows as pending.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p_act <= DEF_P;
                w_act <= DEF_W;
                p_sh  <= DEF_P;
                w_sh  <= DEF_W;
                pend  <= 1'b0;
            end else if (load[i] && apply) begin
                p_act <= p_in;
                w_act <= w_in;
                p_sh  <= p_in;
                w_sh  <= w_in;
                pend  <= 1'b0;
            end else if (load[i]) begin
                p_sh  <= p_in;
                w_sh  <= w_in;
                pend  <= 1'b1;
            end else if (apply && pend) begin
                p_act <= p_sh;
                w_act <= w_sh;
                pend  <= 1'b0;
            end
        end

        assign out[i]     = out_r;
        assign tick[i]    = tick_r;
        assign pending[i] = pend;

    end

endmodule
